// File: rtl/weight_loader_if.sv
// weight_loader_if: read-request, read-return and downstream beat channels of the weight loader.
interface weight_loader_if #(
    parameter int DATA_WIDTH_AXI = 256,
    parameter int ADDR_WIDTH     = 32
);
    logic [ADDR_WIDTH-1:0]     ar_addr;
    logic [7:0]                ar_len;
    logic                      ar_vld;
    logic                      ar_rdy;
    logic [DATA_WIDTH_AXI-1:0] r_dat;
    logic                      r_vld;
    logic                      r_last;
    logic                      r_rdy;
    logic [DATA_WIDTH_AXI-1:0] dn_dat;
    logic                      dn_vld;
    logic                      dn_rdy;
    modport master (
        output ar_addr, ar_len, ar_vld, r_rdy, dn_dat, dn_vld,
        input  ar_rdy, r_dat, r_vld, r_last, dn_rdy
    );
    modport slave (
        input  ar_addr, ar_len, ar_vld, r_rdy, dn_dat, dn_vld,
        output ar_rdy, r_dat, r_vld, r_last, dn_rdy
    );
endinterface

// File: rtl/weight_loader.sv
// weight_loader: fetches butterfly weights from DDR in credit-limited bursts and streams them downstream.
module weight_loader #(
    parameter int DATA_WIDTH_AXI  = 256,
    parameter int DATA_WIDTH_BRAM = 16,
    parameter int ADDR_WIDTH      = 32,
    parameter int MAX_BURST       = 16,
    parameter int FIFO_DEPTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [15:0]           length,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    weight_loader_if.master       bus
);
    localparam int WPB = DATA_WIDTH_AXI / DATA_WIDTH_BRAM;
    localparam int BEAT_BYTES = DATA_WIDTH_AXI / 8;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {IDLE, CALC, RUN, DONE} state_t;
    state_t state, state_nxt;

    logic [15:0]               len_q, total, beats_req, beats_out, rem, burst, lg, prod, total_calc;
    logic [ADDR_WIDTH-1:0]     base_q;
    logic [CW-1:0]             count, inflight, space;
    logic [OW-1:0]             outstanding;
    logic [PW-1:0]             wptr, rptr;
    logic [DATA_WIDTH_AXI-1:0] mem [FIFO_DEPTH];
    logic                      accept, ar_fire, r_run, r_bad, wr, rd;

    always_comb begin
        lg = '0;
        for (int i = 0; i < 16; i++) if (len_q[i]) lg = 16'(i);
        prod = (lg * len_q) << 1;
        total_calc = (prod + 16'(WPB - 1)) / 16'(WPB);
    end

    assign accept = start && state == IDLE;
    assign rem    = total - beats_req;
    assign burst  = rem > 16'(MAX_BURST) ? 16'(MAX_BURST) : rem;
    // count + inflight only shrinks while a request waits, so the request stays stable until accepted
    assign space  = CW'(FIFO_DEPTH) - count - inflight;
    assign bus.ar_vld  = state == RUN && beats_req < total && outstanding < OW'(MAX_OUTSTANDING) && 16'(space) >= burst;
    assign bus.ar_addr = bus.ar_vld ? base_q + ADDR_WIDTH'(beats_req) * ADDR_WIDTH'(BEAT_BYTES) : '0;
    assign bus.ar_len  = bus.ar_vld ? 8'(burst - 16'd1) : '0;
    assign bus.r_rdy   = 1'b1;
    assign ar_fire = bus.ar_vld && bus.ar_rdy;
    assign r_run   = bus.r_vld && state == RUN;
    assign r_bad   = bus.r_vld && (state != RUN || count == CW'(FIFO_DEPTH));
    assign wr      = r_run && count != CW'(FIFO_DEPTH);
    assign bus.dn_vld = count != '0;
    assign bus.dn_dat = bus.dn_vld ? mem[rptr] : '0;
    assign rd      = bus.dn_vld && bus.dn_rdy;

    always_comb begin
        busy = state == CALC || state == RUN;
        done = state == DONE;
        case (state)
            IDLE:    state_nxt = start ? CALC : IDLE;
            CALC:    state_nxt = RUN;
            RUN:     state_nxt = beats_out + 16'(rd) == total ? DONE : RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            len_q       <= '0;
            base_q      <= '0;
            total       <= '0;
            beats_req   <= '0;
            beats_out   <= '0;
            inflight    <= '0;
            outstanding <= '0;
            count       <= '0;
            wptr        <= '0;
            rptr        <= '0;
            err         <= 1'b0;
        end else begin
            state       <= state_nxt;
            err         <= r_bad | (err & ~accept);
            if (state == CALC) total <= total_calc;
            if (ar_fire) beats_req <= beats_req + burst;
            beats_out   <= beats_out + 16'(rd);
            inflight    <= inflight + (ar_fire ? CW'(burst) : '0) - CW'(r_run && inflight != '0);
            outstanding <= outstanding + OW'(ar_fire) - OW'(r_run && bus.r_last && outstanding != '0);
            count       <= count + CW'(wr) - CW'(rd);
            if (wr) wptr <= wptr + 1'b1;
            if (rd) rptr <= rptr + 1'b1;
            if (accept) begin
                len_q       <= length;
                base_q      <= base_addr;
                beats_req   <= '0;
                beats_out   <= '0;
                inflight    <= '0;
                outstanding <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wptr] <= bus.r_dat;
    end
endmodule

// File: doc/weight_loader.md
Name: weight_loader

Overview:
- DDR-side producer that feeds the butterfly weight buffer over its up_dat/up_vld/up_rdy stream.
- On start, computes the weight count for a butterfly of size length (clog2(length) stages × 2·length weights of DATA_WIDTH_BRAM bits) and issues AXI-style read bursts from base_addr.
- Buffers returned beats in a credit-protected FIFO and streams them downstream with valid/ready handshaking.

Parameters:
- DATA_WIDTH_AXI, 256, read-data and dn_dat beat width.
- DATA_WIDTH_BRAM, 16, width of one weight; WPB = DATA_WIDTH_AXI/DATA_WIDTH_BRAM weights per beat.
- ADDR_WIDTH, 32, DDR byte-address width.
- MAX_BURST, 16, maximum beats per read burst (≤256).
- FIFO_DEPTH, 32, beat FIFO depth (power of two, ≥ MAX_BURST).
- MAX_OUTSTANDING, 2, maximum accepted-but-incomplete bursts.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; sampled only in IDLE.
- length  in  16  butterfly size, power of two; sampled with start.
- base_addr  in  ADDR_WIDTH  byte address of first weight, 4 KB aligned; sampled with start.
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  one-cycle pulse when the last beat is handed downstream.
- err  out  1  sticky; set on r beat with FIFO full or r beat outside RUN; cleared by rst or accepted start.
- ar_addr  out  ADDR_WIDTH  burst start byte address.
- ar_len  out  8  beats-1 (AXI encoding).
- ar_vld  out  1  request valid.
- ar_rdy  in  1  request accepted when ar_vld&ar_rdy.
- r_dat  in  DATA_WIDTH_AXI  read beat.
- r_vld  in  1  read beat valid.
- r_last  in  1  last beat of burst.
- r_rdy  out  1  constant 1 (credit scheme guarantees space).
- dn_dat  out  DATA_WIDTH_AXI  weight beat to weight buffer.
- dn_vld  out  1  beat valid.
- dn_rdy  in  1  downstream ready.

Behaviour:
- Reset values: busy=0, done=0, err=0, ar_vld=0, ar_addr=0, ar_len=0, dn_vld=0, dn_dat=0, r_rdy=1; FIFO empty; all counters 0; state IDLE.
- FSM: IDLE -(start)-> CALC -> RUN -(beats_out==total)-> DONE -> IDLE.
  - CALC (1 cycle): total = ceil(clog2(length)·2·length / WPB); 16-bit intermediate math, total 16 bits; length≤1 gives total=0.
  - RUN with total=0 exits on its first cycle; no AR issued.
  - DONE: done=1 for exactly one cycle; busy drops the same cycle.
- Start outside IDLE is ignored.
- Issue rule in RUN: burst = min(MAX_BURST, total-beats_req); request when beats_req<total, outstanding<MAX_OUTSTANDING, and FIFO_DEPTH - fifo_count - inflight ≥ burst.
  - ar_addr = base_addr + beats_req·(DATA_WIDTH_AXI/8); ar_len = burst-1.
  - ar_vld, ar_addr and ar_len hold stable until ar_rdy.
  - On handshake: beats_req += burst; inflight += burst; outstanding += 1.
  - Next request may assert the cycle after a handshake.
- Read return: each r_vld beat in RUN writes FIFO and decrements inflight; r_last decrements outstanding.
  - Same-cycle AR handshake and r_last: outstanding net unchanged; inflight updated by both.
- Downstream: first-word-fall-through; beat written at cycle t is presented on dn_vld/dn_dat at t+1.
  - Transfer occurs on dn_vld&dn_rdy; dn_dat holds while dn_vld&!dn_rdy.
  - beats_out += 1 per transfer; simultaneous FIFO read and write keeps fifo_count.
- Boundaries:
  - FIFO full with r_vld: beat dropped, err=1.
  - r_vld in IDLE/CALC/DONE: dropped, err=1 (covers stale returns after reset).
  - Bursts never cross 4 KB, given aligned base and MAX_BURST·beat bytes ≤ 4096.
- Reset mid-operation: immediate return to reset values; FIFO flushed; pending AR dropped.

Test Plan:
- length=8, base=0x1000, ar_rdy=1, 1-cycle read latency, dn_rdy=1 -> total=3; one AR addr=0x1000 len=2; 3 dn beats in order; done pulse the cycle after the third transfer.
- length=64, dn_rdy=0 -> total=48; ARs at 0x0 and 0x200 with len=15; no third AR while FIFO holds 32.
  - Then dn_rdy=1 -> third AR at 0x400 once 16 beats drain; 48 beats out; done=1.
- length=2 -> total=1 (ceil of 4/16); single AR len=0; one beat; done.
- length=1 -> no AR; done pulses 2 cycles after CALC; busy high exactly 2 cycles.
- r_vld injected while IDLE -> beat not forwarded, dn_vld stays 0, err=1; next accepted start clears err.
- rst asserted during RUN of length=64 after 10 beats out -> all outputs at reset values the same cycle.
  - Then new start with length=8 -> completes cleanly with 3 beats.
